common_regs_v2: RTL and testbench
=================================

COMMON_REGS_V2 -- requirements
Module: common_regs_v2

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, register/data width (fixed at 32 for this block).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 12, byte address width.
REQ-003 SHALL have parameter C_BASE, default 4'h0, page id matched against address bits [11:8].
REQ-004 SHALL have parameter C_NUM_SCRATCH, default 4, scratch register count, legal range 1..8.
REQ-005 SHALL have parameter C_NUM_EVENTS, default 8, event input count, legal range 1..32.
REQ-006 SHALL have parameter C_VERSION, default 32'h0002_0000, version word.
REQ-007 SHALL have parameter C_BUILD_DATE, default 32'h0, build date word.
REQ-008 SHALL have ports (one per line):
  S_AXI_ACLK  in  1  sole clock; all logic on its rising edge.
  S_AXI_ARESETN  in  1  asynchronous, active-low reset.
  S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write byte address.
  S_AXI_WDATA  in  32  write data.
  S_AXI_WSTRB  in  4  write byte strobes.
  S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read byte address.
  common_reg_wren  in  1  single-cycle write strobe.
  common_reg_rden  in  1  single-cycle read strobe.
  evt_in  in  C_NUM_EVENTS  asynchronous-to-software event levels, synchronous to S_AXI_ACLK.
  common_reg_data  out  32  registered read data.
  common_reg_rvalid  out  1  one-cycle pulse, read data valid.
  irq  out  1  registered level interrupt.

Function
REQ-009 SHALL decode a register access only when addr[11:8]==C_BASE, using word index addr[7:2].
REQ-010 SHALL implement this map: 0x00 VERSION (RO, C_VERSION); 0x01 BUILD_DATE (RO); 0x02 CAPS (RO, [3:0]=C_NUM_SCRATCH, [13:8]=C_NUM_EVENTS); 0x03 CTRL (RW); 0x04 CNT_LO (RO); 0x05 CNT_HI (RO, snapshot); 0x06 EVT_STATUS (W1C); 0x07 EVT_MASK (RW); 0x08..0x08+C_NUM_SCRATCH-1 SCRATCH (RW).
REQ-011 SHALL define CTRL bit0 = counter enable (RW), bit1 = counter clear (write-1 pulse, always reads 0), bit2 = irq global enable (RW); all other bits read 0.
REQ-012 SHALL apply RW and W1C writes per byte lane according to S_AXI_WSTRB; lanes with a strobe of 0 are unchanged.
REQ-013 SHALL ignore writes to RO, unmapped, or off-page addresses, and writes to unimplemented bits.
REQ-014 SHALL register read data: common_reg_rden in cycle N gives common_reg_data and a common_reg_rvalid pulse in cycle N+1.
REQ-015 SHALL hold common_reg_data between reads.
REQ-016 SHALL return 0 with rvalid for unmapped or off-page reads.
REQ-017 SHALL return the pre-write value when a read and a write hit the same register in the same cycle.
REQ-018 SHALL keep a 64-bit free-running counter that increments by 1 per cycle while CTRL.bit0=1 and wraps from 2^64-1 to 0.
REQ-019 SHALL give a CTRL.bit1 clear priority over increment in the same cycle; the counter reads 0 in the next cycle.
REQ-020 SHALL, on a CNT_LO read, return the low 32 bits and latch the high 32 bits into CNT_HI in the same cycle; CNT_HI reads return only the latched value.
REQ-021 SHALL detect rising edges of each evt_in bit against a one-cycle-delayed copy and set the matching EVT_STATUS bit, which stays set until written with 1.
REQ-022 SHALL let a set win over a W1C clear on the same bit in the same cycle.
REQ-023 SHALL register irq as OR(EVT_STATUS & EVT_MASK) AND CTRL.bit2, updated one cycle after the contributing state changes.

Reset
REQ-024 SHALL, on ARESETN low, asynchronously clear CTRL, counter, CNT_HI snapshot, EVT_STATUS, EVT_MASK, all SCRATCH, the evt_in delay register, common_reg_data, common_reg_rvalid, and irq to 0.
REQ-025 SHALL, on reset release, not set any EVT_STATUS bit for an evt_in already high; only a subsequent 0->1 transition sets it.
REQ-026 SHALL, on reset asserted mid-read, suppress the rvalid pulse.

Verification
REQ-027 SHALL cover: read 0x00 on page C_BASE -> data 32'h0002_0000 with rvalid exactly one cycle after rden; the same read off-page -> data 0 with rvalid.
REQ-028 SHALL cover: write 0xAABBCCDD with WSTRB=4'b0101 to SCRATCH0 after reset -> reads 0x00BB00DD; write to SCRATCH index C_NUM_SCRATCH -> reads 0.
REQ-029 SHALL cover: CTRL=1 for 10 cycles, then read CNT_LO -> value within +/-1 cycle of 10; CNT_HI=0; a force-preloaded counter at 0xFFFFFFFF_FFFFFFFF wraps to 0.
REQ-030 SHALL cover: pulse evt_in[3] with mask bit3=1 and CTRL=4 -> irq high two cycles after the edge; W1C 0x8 -> irq low; a W1C coincident with a new edge -> bit stays set.
REQ-031 SHALL cover: CTRL written 3 (enable plus clear) while the counter is running -> counter reads 0 then increments; CTRL reads back 1.

Source files
------------

// File: rtl/common_regs_v2.sv
`default_nettype none
// ============================================================================
// Module   : common_regs_v2
// Brief    : Common register page: version/caps, 64-bit counter with snapshot,
//            W1C event status with mask and irq, scratch registers.
// Revision : 2.0
// ============================================================================
module common_regs_v2 #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 12,
  parameter logic [3:0]  C_BASE             = 4'h0,
  parameter int          C_NUM_SCRATCH      = 4,
  parameter int          C_NUM_EVENTS       = 8,
  parameter logic [31:0] C_VERSION          = 32'h0002_0000,
  parameter logic [31:0] C_BUILD_DATE       = 32'h0
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            common_reg_wren,
  input  logic                            common_reg_rden,
  input  logic [C_NUM_EVENTS-1:0]         evt_in,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   common_reg_data,
  output logic                            common_reg_rvalid,
  output logic                            irq
);

  localparam logic [5:0] C_IDX_VERSION  = 6'h00;
  localparam logic [5:0] C_IDX_BUILD    = 6'h01;
  localparam logic [5:0] C_IDX_CAPS     = 6'h02;
  localparam logic [5:0] C_IDX_CTRL     = 6'h03;
  localparam logic [5:0] C_IDX_CNT_LO   = 6'h04;
  localparam logic [5:0] C_IDX_CNT_HI   = 6'h05;
  localparam logic [5:0] C_IDX_EVT_ST   = 6'h06;
  localparam logic [5:0] C_IDX_EVT_MASK = 6'h07;
  localparam logic [5:0] C_IDX_SCRATCH  = 6'h08;

  logic [5:0]  w_wr_idx;
  logic [5:0]  w_rd_idx;
  logic        w_wr_page;
  logic        w_rd_page;
  logic [31:0] w_lane_mask;
  logic [31:0] w_wdata_m;
  logic        w_wr_ctrl;
  logic        w_wr_evt_st;
  logic        w_wr_evt_mask;
  logic        w_cnt_clr;
  logic        w_rd_cnt_lo;
  logic        w_unused;

  logic        r_cnt_en;
  logic        r_irq_en;
  logic [63:0] r_cnt;
  logic [31:0] r_cnt_hi;

  logic [C_NUM_EVENTS-1:0] r_evt_d;
  logic                    r_evt_armed;
  logic [C_NUM_EVENTS-1:0] r_evt_status;
  logic [C_NUM_EVENTS-1:0] r_evt_mask;
  logic [C_NUM_EVENTS-1:0] w_evt_rise;
  logic [C_NUM_EVENTS-1:0] w_evt_clr;
  logic [31:0]             w_status32;
  logic [31:0]             w_mask32;
  logic [31:0]             w_mask_next;

  logic [31:0] r_scratch [C_NUM_SCRATCH];
  logic [31:0] w_scr_rd;
  logic [31:0] w_caps;
  logic [31:0] w_rd_data;

  assign w_unused  = ^{S_AXI_AWADDR, S_AXI_ARADDR};
  assign w_wr_idx  = S_AXI_AWADDR[7:2];
  assign w_rd_idx  = S_AXI_ARADDR[7:2];
  assign w_wr_page = common_reg_wren && (S_AXI_AWADDR[11:8] == C_BASE);
  assign w_rd_page = (S_AXI_ARADDR[11:8] == C_BASE);

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      w_lane_mask[b*8 +: 8] = {8{S_AXI_WSTRB[b]}};
    end
  end
  assign w_wdata_m = S_AXI_WDATA & w_lane_mask;

  assign w_wr_ctrl     = w_wr_page && (w_wr_idx == C_IDX_CTRL);
  assign w_wr_evt_st   = w_wr_page && (w_wr_idx == C_IDX_EVT_ST);
  assign w_wr_evt_mask = w_wr_page && (w_wr_idx == C_IDX_EVT_MASK);
  assign w_cnt_clr     = w_wr_ctrl && S_AXI_WSTRB[0] && S_AXI_WDATA[1];
  assign w_rd_cnt_lo   = common_reg_rden && w_rd_page && (w_rd_idx == C_IDX_CNT_LO);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_cnt_en <= 1'b0;
      r_irq_en <= 1'b0;
    end else if (w_wr_ctrl && S_AXI_WSTRB[0]) begin
      r_cnt_en <= S_AXI_WDATA[0];
      r_irq_en <= S_AXI_WDATA[2];
    end
  end

  // Clear outranks increment; the snapshot only moves on a CNT_LO read.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_cnt    <= 64'd0;
      r_cnt_hi <= 32'd0;
    end else begin
      if (w_cnt_clr) begin
        r_cnt <= 64'd0;
      end else if (r_cnt_en) begin
        r_cnt <= r_cnt + 64'd1;
      end
      if (w_rd_cnt_lo) begin
        r_cnt_hi <= r_cnt[63:32];
      end
    end
  end

  // Edge detection is held off for one cycle after reset so levels already
  // high at release are not reported as events.
  assign w_evt_rise = evt_in & ~r_evt_d & {C_NUM_EVENTS{r_evt_armed}};
  assign w_evt_clr  = w_wr_evt_st ? w_wdata_m[C_NUM_EVENTS-1:0] : '0;

  always_comb begin
    w_status32 = '0;
    w_mask32   = '0;
    w_status32[C_NUM_EVENTS-1:0] = r_evt_status;
    w_mask32[C_NUM_EVENTS-1:0]   = r_evt_mask;
  end
  assign w_mask_next = (w_mask32 & ~w_lane_mask) | w_wdata_m;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_evt_d      <= '0;
      r_evt_armed  <= 1'b0;
      r_evt_status <= '0;
      r_evt_mask   <= '0;
      irq          <= 1'b0;
    end else begin
      r_evt_d      <= evt_in;
      r_evt_armed  <= 1'b1;
      r_evt_status <= (r_evt_status & ~w_evt_clr) | w_evt_rise;
      if (w_wr_evt_mask) begin
        r_evt_mask <= w_mask_next[C_NUM_EVENTS-1:0];
      end
      irq <= r_irq_en && (|(r_evt_status & r_evt_mask));
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < C_NUM_SCRATCH; gi++) begin : g_scratch
      always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
          r_scratch[gi] <= 32'd0;
        end else if (w_wr_page && (w_wr_idx == 6'(C_IDX_SCRATCH + gi))) begin
          r_scratch[gi] <= (r_scratch[gi] & ~w_lane_mask) | w_wdata_m;
        end
      end
    end
  endgenerate

  always_comb begin
    w_scr_rd = 32'd0;
    for (int i = 0; i < C_NUM_SCRATCH; i++) begin
      if (w_rd_idx == 6'(C_IDX_SCRATCH + i)) begin
        w_scr_rd = r_scratch[i];
      end
    end
  end

  always_comb begin
    w_caps        = 32'd0;
    w_caps[3:0]   = 4'(C_NUM_SCRATCH);
    w_caps[13:8]  = 6'(C_NUM_EVENTS);
  end

  always_comb begin
    w_rd_data = 32'd0;
    if (w_rd_page) begin
      case (w_rd_idx)
        C_IDX_VERSION:  w_rd_data = C_VERSION;
        C_IDX_BUILD:    w_rd_data = C_BUILD_DATE;
        C_IDX_CAPS:     w_rd_data = w_caps;
        C_IDX_CTRL:     w_rd_data = {29'd0, r_irq_en, 1'b0, r_cnt_en};
        C_IDX_CNT_LO:   w_rd_data = r_cnt[31:0];
        C_IDX_CNT_HI:   w_rd_data = r_cnt_hi;
        C_IDX_EVT_ST:   w_rd_data = w_status32;
        C_IDX_EVT_MASK: w_rd_data = w_mask32;
        default:        w_rd_data = w_scr_rd;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      common_reg_data   <= '0;
      common_reg_rvalid <= 1'b0;
    end else begin
      common_reg_rvalid <= common_reg_rden;
      if (common_reg_rden) begin
        common_reg_data <= w_rd_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_common_regs_v2.sv
`default_nettype none
// ============================================================================
// Module   : tb_common_regs_v2
// Brief    : Scoreboard bench for common_regs_v2 register page.
// Revision : 2.0
// ============================================================================
module tb_common_regs_v2;

  typedef struct {
    string       tag;
    logic [31:0] exp;
    int          tol;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] awaddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [11:0] araddr = '0;
  logic        wren = 1'b0;
  logic        rden = 1'b0;
  logic [7:0]  evt = '0;
  logic [31:0] rdata;
  logic        rvalid;
  logic        irq;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  always #5 clk = ~clk;

  common_regs_v2 dut (
    .S_AXI_ACLK       (clk),
    .S_AXI_ARESETN    (rst_n),
    .S_AXI_AWADDR     (awaddr),
    .S_AXI_WDATA      (wdata),
    .S_AXI_WSTRB      (wstrb),
    .S_AXI_ARADDR     (araddr),
    .common_reg_wren  (wren),
    .common_reg_rden  (rden),
    .evt_in           (evt),
    .common_reg_data  (rdata),
    .common_reg_rvalid(rvalid),
    .irq              (irq)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    awaddr = a; wdata = d; wstrb = s; wren = 1'b1;
    @(negedge clk);
    wren = 1'b0;
  endtask

  task automatic do_read(input logic [11:0] a, input logic [31:0] e, input string tag,
                         input int tol = 0);
    araddr = a; rden = 1'b1;
    sb_q.push_back('{tag, e, tol});
    @(negedge clk);
    rden = 1'b0;
  endtask

  task automatic do_rw(input logic [11:0] a, input logic [31:0] d, input logic [31:0] e,
                       input string tag);
    awaddr = a; wdata = d; wstrb = 4'hF; wren = 1'b1;
    araddr = a; rden = 1'b1;
    sb_q.push_back('{tag, e, 0});
    @(negedge clk);
    wren = 1'b0; rden = 1'b0;
  endtask

  // rvalid must follow rden by exactly one edge; data is popped from the scoreboard
  always @(posedge clk) begin
    logic exp_v;
    sb_t  e;
    int   diff;
    exp_v = rden && rst_n;
    #1;
    if (rvalid || exp_v) check_val("rvalid", rvalid, exp_v);
    if (rvalid) begin
      if (sb_q.size() == 0) begin
        check_val("sb_underflow", sb_q.size(), 1);
      end else begin
        e = sb_q.pop_front();
        if (e.tol == 0) begin
          check_val(e.tag, rdata, e.exp);
        end else begin
          diff = int'(rdata) - int'(e.exp);
          if (diff < -e.tol || diff > e.tol) $display("  %s raw=0x%0h", e.tag, rdata);
          check_val({e.tag, "_in_tol"}, (diff >= -e.tol && diff <= e.tol), 1);
        end
      end
    end
  end

  initial begin
    evt = 8'h01;
    #12;
    check_val("rst_data", rdata, 0);
    check_val("rst_rvalid", rvalid, 0);
    check_val("rst_irq", irq, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_read(12'h000, 32'h0002_0000, "version");
    do_read(12'h100, 32'h0, "version_offpage");
    do_read(12'h004, 32'h0, "build_date");
    do_read(12'h008, 32'h0000_0804, "caps");
    do_read(12'h018, 32'h0, "evt_st_after_rst");
    evt = 8'h00;
    do_read(12'h040, 32'h0, "unmapped");

    do_write(12'h020, 32'hAABB_CCDD, 4'b0101);
    do_read(12'h020, 32'h00BB_00DD, "scratch0_strb");
    repeat (3) @(negedge clk);
    check_val("data_hold", rdata, 32'h00BB_00DD);
    do_write(12'h030, 32'h1234_5678, 4'hF);
    do_read(12'h030, 32'h0, "scratch_oob");
    do_write(12'h02C, 32'hCAFE_F00D, 4'hF);
    do_read(12'h02C, 32'hCAFE_F00D, "scratch3");
    do_write(12'h000, 32'hFFFF_FFFF, 4'hF);
    do_read(12'h000, 32'h0002_0000, "version_ro");
    do_write(12'h124, 32'h5555_5555, 4'hF);
    do_read(12'h024, 32'h0, "scratch1_offpage_wr");
    do_write(12'h024, 32'h1111_1111, 4'hF);
    do_rw(12'h024, 32'h2222_2222, 32'h1111_1111, "rw_prewrite");
    do_read(12'h024, 32'h2222_2222, "rw_after");

    do_write(12'h00C, 32'h1, 4'h1);
    repeat (10) @(negedge clk);
    do_read(12'h010, 32'd10, "cnt_lo_10", 1);
    do_read(12'h014, 32'h0, "cnt_hi_0");
    do_read(12'h00C, 32'h1, "ctrl_en");
    do_write(12'h00C, 32'h3, 4'h1);
    do_read(12'h010, 32'd0, "cnt_clr_0");
    do_read(12'h010, 32'd1, "cnt_clr_inc");
    do_read(12'h00C, 32'h1, "ctrl_rb_1");

    do_write(12'h00C, 32'h0, 4'h1);
    force dut.r_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    release dut.r_cnt;
    do_read(12'h010, 32'hFFFF_FFFF, "cnt_lo_max");
    do_read(12'h014, 32'hFFFF_FFFF, "cnt_hi_max");
    do_write(12'h00C, 32'h1, 4'h1);
    do_write(12'h00C, 32'h0, 4'h1);
    do_read(12'h010, 32'h0, "cnt_wrap_lo");
    do_read(12'h014, 32'h0, "cnt_wrap_hi");

    do_write(12'h01C, 32'h8, 4'h1);
    do_write(12'h00C, 32'h4, 4'h1);
    evt[3] = 1'b1;
    @(posedge clk); #1;
    check_val("irq_edge_plus1", irq, 0);
    @(posedge clk); #1;
    check_val("irq_edge_plus2", irq, 1);
    @(negedge clk);
    evt[3] = 1'b0;
    do_read(12'h018, 32'h8, "evt_st_set");
    do_write(12'h018, 32'h8, 4'h0);
    do_read(12'h018, 32'h8, "evt_w1c_nostrb");
    do_write(12'h018, 32'h8, 4'h1);
    @(posedge clk); #1;
    check_val("irq_cleared", irq, 0);
    @(negedge clk);
    do_read(12'h018, 32'h0, "evt_st_clr");
    evt[3] = 1'b1;
    do_write(12'h018, 32'h8, 4'h1);
    do_read(12'h018, 32'h8, "evt_set_wins");
    check_val("irq_set_wins", irq, 1);
    evt[3] = 1'b0;
    do_write(12'h018, 32'hFF, 4'h1);

    araddr = 12'h000; rden = 1'b1;
    #3 rst_n = 1'b0;
    @(posedge clk); #1;
    check_val("rst_mid_read_rvalid", rvalid, 0);
    @(negedge clk);
    rden = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_read(12'h020, 32'h0, "scratch0_after_rst");
    do_read(12'h00C, 32'h0, "ctrl_after_rst");
    do_read(12'h01C, 32'h0, "mask_after_rst");
    repeat (3) @(negedge clk);
    check_val("sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
